// File: rtl/fetch_unit_if.sv
// Program-memory and decoder bus of fetch_unit: ROM address/data, decoded
// opcode/operand with their Valid qualifier, and the decoder's WrPC reply.
interface fetch_unit_if #(
  parameter int ADDR_W  = 11,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  InstrAddr;
  logic [INSTR_W-1:0] InstrData;
  logic [4:0]         OpCode;
  logic [ADDR_W-1:0]  Operand;
  logic               Valid;
  logic               WrPC;

  modport master (
    output InstrAddr, OpCode, Operand, Valid,
    input  InstrData, WrPC
  );

  modport slave (
    input  InstrAddr, OpCode, Operand, Valid,
    output InstrData, WrPC
  );
endinterface

// File: rtl/fetch_unit.sv
// Non-pipelined fetch FSM: FETCH -> LOAD -> EXEC per instruction, HALT until Resume.
// Define FETCH_CYCLE_COUNT_EN to build the saturating non-HALT cycle counter.
module fetch_unit #(
  parameter int ADDR_W  = 11,
  parameter int INSTR_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Resume,
  fetch_unit_if.master        bus,
  output logic                Halted,
  output logic                HaltEvent,
  output logic [15:0]         CycleCount
);

  typedef enum logic [1:0] {FETCH, LOAD, EXEC, HALT} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               halt_event_q, halt_event_d;
  logic               valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = LOAD;
      LOAD:    state_d = EXEC;
      EXEC:    state_d = bus.WrPC ? FETCH : HALT;
      HALT:    if (Resume) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // WrPC only matters in EXEC, Resume only in HALT; elsewhere both are ignored.
  always_comb begin
    pc_d         = pc_q;
    ir_d         = ir_q;
    halt_event_d = (state_q == EXEC) && !bus.WrPC;
    if (state_q == LOAD) begin
      ir_d = bus.InstrData;
    end
    if (state_q == EXEC && bus.WrPC) begin
      pc_d = pc_q + ADDR_W'(1);
    end
    if (state_q == HALT && Resume) begin
      pc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= '0;
      ir_q         <= '0;
      halt_event_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      halt_event_q <= halt_event_d;
    end
  end

  always_comb begin
    valid         = (state_q == EXEC);
    bus.Valid     = valid;
    bus.InstrAddr = pc_q;
    bus.OpCode    = valid ? ir_q[INSTR_W-1 -: 5] : '0;
    bus.Operand   = valid ? ir_q[ADDR_W-1:0] : '0;
    Halted        = (state_q == HALT);
    HaltEvent     = halt_event_q;
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == HALT) begin
      if (Resume) cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb CycleCount = cnt_q;
`else
  always_comb CycleCount = '0;
`endif

endmodule
